pressure_alarm_ctrl: RTL and testbench

//  Downstream consumer of the combinational pressure-warning flag (pWarning).

---
 rtl/pressure_alarm_ctrl_pkg.sv | 23 ++
 rtl/pressure_alarm_ctrl_if.sv | 24 ++
 rtl/pressure_alarm_ctrl_beep_divider.sv | 38 +++
 rtl/pressure_alarm_ctrl.sv | 129 ++++++++++++
 tb/tb_pressure_alarm_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pressure_alarm_ctrl_pkg.sv
// Shared definitions for the pressure alarm controller: state encoding,
// default qualification/clear/buzzer parameters and counter widths.
package pressure_alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_ALARM   = 2'd2,
        ST_ACKED   = 2'd3
    } state_t;

    localparam int RAISE_CNT_DEF = 4;
    localparam int CLEAR_CNT_DEF = 8;
    localparam int BEEP_HALF_DEF = 25;
    localparam int WARN_W        = 8;
    // qual/clean run lengths are limited to 1..15
    localparam int CNT_W         = 4;

    function automatic logic [WARN_W-1:0] sat_inc(input logic [WARN_W-1:0] v);
        return (v == {WARN_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pressure_alarm_ctrl_if.sv
// Sample/ack inputs and alarm status outputs of the pressure alarm controller.
interface pressure_alarm_ctrl_if;
    import pressure_alarm_ctrl_pkg::*;

    logic              sampleValid;
    logic              pWarning;
    logic              ack;
    logic              alarmActive;
    logic              alarmUnacked;
    logic              alarmEvent;
    logic              buzzer;
    logic [WARN_W-1:0] warnCount;

    modport master (
        output sampleValid, pWarning, ack,
        input  alarmActive, alarmUnacked, alarmEvent, buzzer, warnCount
    );

    modport slave (
        input  sampleValid, pWarning, ack,
        output alarmActive, alarmUnacked, alarmEvent, buzzer, warnCount
    );

endinterface

// File: rtl/pressure_alarm_ctrl_beep_divider.sv
// Buzzer square-wave generator: high on the restart cycle, toggles every
// BEEP_HALF enabled cycles, forced low while disabled.
module beep_divider #(
    parameter int BEEP_HALF = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic buzzer
);

    localparam int             DIV_W    = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEEP_HALF - 1);

    logic [DIV_W-1:0] div;

    // restart and enable are both computed from the next FSM state, so the
    // wave lines up with the first cycle spent in ALARM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            buzzer <= 1'b0;
        end else if (restart) begin
            div    <= '0;
            buzzer <= 1'b1;
        end else if (!enable) begin
            div    <= '0;
            buzzer <= 1'b0;
        end else if (div == DIV_LAST) begin
            div    <= '0;
            buzzer <= ~buzzer;
        end else begin
            div    <= div + 1'b1;
        end
    end

endmodule

// File: rtl/pressure_alarm_ctrl.sv
// Pressure alarm FSM: qualifies pWarning over sample strobes, latches the alarm
// until acknowledged, and clears after a clean run of samples.
module pressure_alarm_ctrl
    import pressure_alarm_ctrl_pkg::*;
#(
    parameter int RAISE_CNT = RAISE_CNT_DEF,
    parameter int CLEAR_CNT = CLEAR_CNT_DEF,
    parameter int BEEP_HALF = BEEP_HALF_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pressure_alarm_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] RAISE_LAST = CNT_W'(RAISE_CNT);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CNT);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  qual, qual_nxt, qual_inc;
    logic [CNT_W-1:0]  clean, clean_nxt, clean_inc;
    logic              entering, beep_en;
    logic              active_q, unacked_q, event_q, buzzer_q;
    logic [WARN_W-1:0] warn_q;

    assign qual_inc  = qual + 1'b1;
    assign clean_inc = clean + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            qual  <= '0;
            clean <= '0;
        end else begin
            state <= state_nxt;
            qual  <= qual_nxt;
            clean <= clean_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        qual_nxt  = qual;
        clean_nxt = clean;
        case (state)
            ST_IDLE: begin
                if (bus.sampleValid && bus.pWarning) begin
                    if (RAISE_CNT == 1) begin
                        state_nxt = ST_ALARM;
                        qual_nxt  = '0;
                    end else begin
                        state_nxt = ST_PENDING;
                        qual_nxt  = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (bus.sampleValid) begin
                    if (!bus.pWarning) begin
                        state_nxt = ST_IDLE;
                        qual_nxt  = '0;
                    end else if (qual_inc == RAISE_LAST) begin
                        state_nxt = ST_ALARM;
                        qual_nxt  = '0;
                    end else begin
                        qual_nxt  = qual_inc;
                    end
                end
            end
            // latching: samples are ignored, and a sample coinciding with ack is dropped
            ST_ALARM: begin
                if (bus.ack) begin
                    state_nxt = ST_ACKED;
                    clean_nxt = '0;
                end
            end
            ST_ACKED: begin
                if (bus.sampleValid) begin
                    if (bus.pWarning) begin
                        clean_nxt = '0;
                    end else if (clean_inc == CLEAR_LAST) begin
                        state_nxt = ST_IDLE;
                        clean_nxt = '0;
                    end else begin
                        clean_nxt = clean_inc;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign entering = (state_nxt == ST_ALARM) && (state != ST_ALARM);
    assign beep_en  = (state_nxt == ST_ALARM);

    // outputs are registered from the next state so they appear on the same
    // edge that moves the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= 1'b0;
            unacked_q <= 1'b0;
            event_q   <= 1'b0;
            warn_q    <= '0;
        end else begin
            active_q  <= (state_nxt == ST_ALARM) || (state_nxt == ST_ACKED);
            unacked_q <= (state_nxt == ST_ALARM);
            event_q   <= entering;
            if (entering) begin
                warn_q <= sat_inc(warn_q);
            end
        end
    end

    beep_divider #(
        .BEEP_HALF (BEEP_HALF)
    ) u_beep (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (beep_en),
        .restart (entering),
        .buzzer  (buzzer_q)
    );

    assign bus.alarmActive  = active_q;
    assign bus.alarmUnacked = unacked_q;
    assign bus.alarmEvent   = event_q;
    assign bus.buzzer       = buzzer_q;
    assign bus.warnCount    = warn_q;

endmodule

// File: tb/tb_pressure_alarm_ctrl.sv
// Scoreboard bench for pressure_alarm_ctrl: stimulus queues expected output
// snapshots and alarm events, a negedge monitor pops and compares them.
module tb_pressure_alarm_ctrl;
    import pressure_alarm_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pressure_alarm_ctrl_if bus();

    pressure_alarm_ctrl #(
        .RAISE_CNT (4),
        .CLEAR_CNT (8),
        .BEEP_HALF (25)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [11:0] exp_q[$];
    string       name_q[$];
    logic [7:0]  ev_q[$];
    logic        chk = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_warn = 8'd0;

    wire [11:0] obs = {bus.alarmActive, bus.alarmUnacked, bus.alarmEvent,
                       bus.buzzer, bus.warnCount};

    always @(negedge clk) begin : monitor
        logic [11:0] e;
        logic [7:0]  ew;
        string       nm;
        if (chk) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL chk_underflow: no expected snapshot queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL %s: act/unack/evt/buz=%b warn=%0d, expected %b warn=%0d",
                             nm, obs[11:8], obs[7:0], e[11:8], e[7:0]);
                end
            end
        end
        if (bus.alarmEvent === 1'b1) begin
            n_cmp++;
            if (ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: warnCount=%0d, no event expected", bus.warnCount);
            end else begin
                ew = ev_q.pop_front();
                if (bus.warnCount !== ew) begin
                    n_bad++;
                    $display("FAIL event_warn: warnCount=%0d, expected %0d", bus.warnCount, ew);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic w);
        bus.sampleValid = 1'b1;
        bus.pWarning    = w;
        tick();
        bus.sampleValid = 1'b0;
        bus.pWarning    = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic a, input logic u,
                           input logic e, input logic b, input logic [7:0] w);
        exp_q.push_back({a, u, e, b, w});
        name_q.push_back(nm);
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic raise_event();
        exp_warn = (exp_warn == 8'd255) ? 8'd255 : exp_warn + 8'd1;
        ev_q.push_back(exp_warn);
    endtask

    initial begin
        bus.sampleValid = 1'b0;
        bus.pWarning    = 1'b0;
        bus.ack         = 1'b0;
        #2;
        chk_out("reset", 0, 0, 0, 0, 8'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // broken warning run never raises; a fourth consecutive W does
        repeat (3) strobe(1'b1);
        strobe(1'b0);
        repeat (3) strobe(1'b1);
        chk_out("no_raise_broken", 0, 0, 0, 0, 8'd0);
        raise_event();
        strobe(1'b1);

        // 60 ALARM cycles with ignored clean strobes: buzzer 25 high / 25 low
        for (int k = 0; k < 60; k++) begin
            bus.sampleValid = (k % 3 == 0);
            chk_out($sformatf("alarm_k%0d", k), 1, 1, (k == 0), ((k / 25) % 2) == 0, exp_warn);
            tick();
            bus.sampleValid = 1'b0;
        end

        // ack with a simultaneous clean strobe: that sample is not counted
        bus.ack = 1'b1;
        bus.sampleValid = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.sampleValid = 1'b0;
        chk_out("acked", 1, 0, 0, 0, exp_warn);
        repeat (7) strobe(1'b0);
        chk_out("ack_sample_dropped", 1, 0, 0, 0, exp_warn);
        strobe(1'b0);
        chk_out("cleared", 0, 0, 0, 0, exp_warn);
        pulse_ack();
        chk_out("ack_idle_ignored", 0, 0, 0, 0, exp_warn);

        // ack on the entry edge is ignored
        repeat (3) strobe(1'b1);
        raise_event();
        bus.ack = 1'b1;
        strobe(1'b1);
        bus.ack = 1'b0;
        chk_out("ack_on_entry", 1, 1, 1, 1, exp_warn);
        repeat (3) tick();
        pulse_ack();
        chk_out("acked2", 1, 0, 0, 0, exp_warn);
        repeat (5) strobe(1'b0);
        strobe(1'b1);
        repeat (7) strobe(1'b0);
        chk_out("clean_restart", 1, 0, 0, 0, exp_warn);
        strobe(1'b0);
        chk_out("cleared2", 0, 0, 0, 0, exp_warn);

        // strobes spaced by idle cycles still qualify
        for (int i = 0; i < 4; i++) begin
            if (i == 3) raise_event();
            strobe(1'b1);
            if (i < 3) repeat (3) tick();
            if (i == 2) chk_out("pending_quiet", 0, 0, 0, 0, exp_warn);
        end
        chk_out("gap_raise", 1, 1, 1, 1, exp_warn);
        tick();
        chk_out("alarm_hold", 1, 1, 0, 1, exp_warn);
        tick();

        // asynchronous reset between edges
        #1 rst_n = 1'b0;
        chk_out("async_reset", 0, 0, 0, 0, 8'd0);
        exp_warn = 8'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        repeat (3) strobe(1'b1);
        raise_event();
        strobe(1'b1);
        chk_out("post_reset_raise", 1, 1, 1, 1, 8'd1);
        pulse_ack();
        repeat (8) strobe(1'b0);
        chk_out("cleared3", 0, 0, 0, 0, 8'd1);

        // 256 more alarms saturate warnCount
        repeat (256) begin
            repeat (3) strobe(1'b1);
            raise_event();
            strobe(1'b1);
            pulse_ack();
            repeat (8) strobe(1'b0);
        end
        chk_out("saturated", 0, 0, 0, 0, 8'd255);

        tick();
        n_cmp++;
        if (ev_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: events=%0d snapshots=%0d, expected 0/0", ev_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
